// File: rtl/state_stream_mux.sv
// Snapshots a wide debug-state vector and streams it byte by byte,
// framed by a header and a trailing XOR checksum, with live passthrough.
module state_stream_mux #(
  parameter int unsigned STATE_BYTES = 64,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     give_state,
  input  logic                     snapshot_req,
  input  logic [STATE_BYTES*8-1:0] state_in,
  input  logic [7:0]               live_byte,
  input  logic                     next_byte,
  output logic [7:0]               output_byte,
  output logic                     byte_valid,
  output logic                     last_byte,
  output logic                     busy,
  output logic                     freeze
);

  localparam int unsigned W  = STATE_BYTES * 8;
  localparam int unsigned IW = $clog2(STATE_BYTES + 2);
  localparam logic [IW-1:0] LAST = IW'(STATE_BYTES + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t        state;
  logic [IW-1:0] index;
  logic [IW-1:0] sel;
  logic [7:0]    xor_acc;
  logic [7:0]    live_q;
  logic [7:0]    sbyte;
  logic [W-1:0]  snap;
  logic          next_prev;
  logic          mode_q;
  logic          adv;
  logic          is_state;

  assign adv      = next_byte & ~next_prev;
  assign sel      = index - IW'(1);
  assign is_state = (index != '0) && (index != LAST);

  // Frame index 1..STATE_BYTES maps to snapshot byte 0..STATE_BYTES-1
  always_comb begin
    sbyte = '0;
    for (int i = 0; i < int'(STATE_BYTES); i++) begin
      if (sel == IW'(i)) begin
        sbyte = snap[W-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      index     <= '0;
      xor_acc   <= '0;
      next_prev <= 1'b0;
      snap      <= '0;
      live_q    <= '0;
      mode_q    <= 1'b0;
    end else begin
      next_prev <= next_byte;
      live_q    <= live_byte;
      mode_q    <= give_state;
      unique case (state)
        IDLE: begin
          if (snapshot_req && give_state) begin
            snap    <= state_in;
            index   <= '0;
            xor_acc <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (!give_state) begin
            state <= IDLE;
          end else if (adv) begin
            if (index == LAST) begin
              state <= IDLE;
            end else begin
              index <= index + IW'(1);
              if (is_state) begin
                xor_acc <= xor_acc ^ sbyte;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state; no input reaches them directly
  always_comb begin
    busy        = (state == SEND);
    freeze      = busy;
    byte_valid  = busy;
    last_byte   = busy && (index == LAST);
    output_byte = IDLE_BYTE;
    if (!mode_q) begin
      output_byte = live_q;
    end else if (!busy) begin
      output_byte = IDLE_BYTE;
    end else if (index == '0) begin
      output_byte = HEADER;
    end else if (index == LAST) begin
      output_byte = xor_acc;
    end else begin
      output_byte = sbyte;
    end
  end

endmodule

// File: tb/tb_state_stream_mux.sv
// Scoreboard bench for state_stream_mux: frame-level reference model,
// per-cycle monitor, directed boundary cases and a random phase.
module tb_state_stream_mux;

  localparam int N = 4;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] IDL = 8'h00;

  logic           clk = 1'b0;
  logic           nrst;
  logic           give_state;
  logic           snapshot_req;
  logic [N*8-1:0] state_in;
  logic [7:0]     live_byte;
  logic           next_byte;
  logic [7:0]     output_byte;
  logic           byte_valid;
  logic           last_byte;
  logic           busy;
  logic           freeze;

  logic [7:0] s1_in;
  logic [7:0] o1_byte;
  logic       o1_valid;
  logic       o1_last;
  logic       o1_busy;
  logic       o1_freeze;

  always #5 clk = ~clk;

  state_stream_mux #(
    .STATE_BYTES(N),
    .HEADER(HDR),
    .IDLE_BYTE(IDL)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .give_state(give_state),
    .snapshot_req(snapshot_req),
    .state_in(state_in),
    .live_byte(live_byte),
    .next_byte(next_byte),
    .output_byte(output_byte),
    .byte_valid(byte_valid),
    .last_byte(last_byte),
    .busy(busy),
    .freeze(freeze)
  );

  state_stream_mux #(
    .STATE_BYTES(1),
    .HEADER(HDR),
    .IDLE_BYTE(IDL)
  ) dut1 (
    .clk(clk),
    .nrst(nrst),
    .give_state(give_state),
    .snapshot_req(snapshot_req),
    .state_in(s1_in),
    .live_byte(live_byte),
    .next_byte(next_byte),
    .output_byte(o1_byte),
    .byte_valid(o1_valid),
    .last_byte(o1_last),
    .busy(o1_busy),
    .freeze(o1_freeze)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       v;
    logic       l;
    logic       bu;
    logic       fr;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model: the frame is a byte list built at snapshot time
  initial begin : model
    bit         act;
    bit         prev;
    bit         gq;
    bit         adv;
    logic [7:0] lq;
    logic [7:0] ck;
    logic [7:0] sb;
    int         pos;
    logic [7:0] frame[$];
    obs_t       e;
    act = 0; prev = 0; gq = 0; lq = '0; pos = 0;
    forever begin
      @(posedge clk);
      if (nrst !== 1'b1) begin
        act = 0; prev = 0; gq = 0; lq = '0;
      end else begin
        adv  = next_byte && !prev;
        prev = next_byte;
        if (act) begin
          if (!give_state) act = 0;
          else if (adv) begin
            if (pos == frame.size() - 1) act = 0;
            else pos++;
          end
        end else if (snapshot_req && give_state) begin
          frame = {};
          frame.push_back(HDR);
          ck = '0;
          for (int i = 0; i < N; i++) begin
            sb = 8'(state_in >> (8 * (N - 1 - i)));
            frame.push_back(sb);
            ck ^= sb;
          end
          frame.push_back(ck);
          pos = 0;
          act = 1;
        end
        gq = give_state;
        lq = live_byte;
      end
      e.b  = !gq ? lq : (!act ? IDL : frame[pos]);
      e.v  = act;
      e.l  = act && (pos == N + 1);
      e.bu = act;
      e.fr = act;
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {output_byte, byte_valid, last_byte, busy, freeze};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got byte=%h v=%b l=%b busy=%b frz=%b expected byte=%h v=%b l=%b busy=%b frz=%b",
                   $time, got.b, got.v, got.l, got.bu, got.fr,
                   e.b, e.v, e.l, e.bu, e.fr);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_step();
    next_byte = 1'b1;
    tick();
    next_byte = 1'b0;
    tick();
  endtask

  task automatic snap();
    snapshot_req = 1'b1;
    tick();
    snapshot_req = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] t1[6];
    logic [7:0] t1s[3];
    logic [7:0] first;
    t1  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    t1s = '{8'hA5, 8'h5A, 8'h5A};
    nrst = 0; give_state = 1; snapshot_req = 0; next_byte = 0;
    state_in = 32'h11223344; s1_in = 8'h5A; live_byte = 8'h00;
    tick(2);
    chk("reset_out", {output_byte, byte_valid, last_byte, busy, freeze}, 0);
    nrst = 1;
    tick();

    // Basic stream, plus the one-byte instance alongside
    snap();
    for (int k = 0; k < 6; k++) begin
      chk("t1_byte", output_byte, t1[k]);
      chk("t1_last", last_byte, (k == 5));
      if (k < 3) begin
        chk("sb1_byte", o1_byte, t1s[k]);
        chk("sb1_last", o1_last, (k == 2));
      end else begin
        chk("sb1_busy", o1_busy, 0);
      end
      edge_step();
    end
    chk("t1_busy_end", busy, 0);

    // Live passthrough; snapshot requests ignored
    give_state = 0;
    for (int v = 0; v < 256; v++) begin
      live_byte = 8'(v);
      snapshot_req = ($urandom % 4) == 0;
      tick();
    end
    snapshot_req = 0;
    chk("t2_busy", busy, 0);

    // Snapshot held while busy
    give_state = 1;
    tick();
    snap();
    edge_step();
    edge_step();
    state_in = 32'hFFFFFFFF;
    snap();
    chk("t3_hold", output_byte, 8'h22);
    state_in = $urandom;
    repeat (4) edge_step();
    chk("t3_busy_end", busy, 0);

    // Abort on give_state falling, then clean restart
    state_in = $urandom;
    snap();
    edge_step();
    give_state = 0;
    live_byte = 8'h3C;
    tick();
    chk("t4_busy", busy, 0);
    chk("t4_freeze", freeze, 0);
    chk("t4_live", output_byte, 8'h3C);
    give_state = 1;
    tick();
    state_in = 32'hDEADBEEF;
    snap();
    chk("t4_hdr", output_byte, 8'hA5);
    repeat (5) edge_step();
    chk("t4_cksum", output_byte, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    edge_step();

    // next_byte held high across reset release
    next_byte = 1; nrst = 0;
    tick(2);
    nrst = 1;
    tick(3);
    first = state_in[31:24];
    snap();
    tick(3);
    chk("t5_no_adv", output_byte, 8'hA5);
    next_byte = 0;
    tick(2);
    chk("t5_still_hdr", output_byte, 8'hA5);
    next_byte = 1;
    tick(8);
    next_byte = 0;
    tick(2);
    chk("t5_one_step", output_byte, first);
    repeat (5) edge_step();
    chk("t5_busy_end", busy, 0);

    // Reset mid-stream
    snap();
    repeat (3) edge_step();
    nrst = 0;
    tick();
    chk("t6_reset", {output_byte, byte_valid, last_byte, busy, freeze}, 0);
    nrst = 1;
    tick();
    snap();
    chk("t6_hdr", output_byte, 8'hA5);
    repeat (6) edge_step();

    // Random phase
    for (int c = 0; c < 2000; c++) begin
      nrst         = ($urandom % 200) != 0;
      give_state   = ($urandom % 20) != 0;
      snapshot_req = ($urandom % 8) == 0;
      if (($urandom % 3) == 0) next_byte = ~next_byte;
      live_byte = 8'($urandom);
      if (($urandom % 16) == 0) state_in = $urandom;
      tick();
    end
    nrst = 1;
    snapshot_req = 0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
